// File: rtl/count_sequencer.sv
// Run controller for a modulo counter: takes a limit/mode config, then sequences
// one-shot or continuous runs under start/pause/abort, reporting value, pulses and laps.
module count_sequencer #(
  parameter int WIDTH         = 7,
  parameter int DEFAULT_LIMIT = 100,
  parameter int LAP_W         = 8
) (
  input  logic             i_clock,
  input  logic             i_reset_async_n,
  input  logic             i_cfg_valid,
  output logic             o_cfg_ready,
  input  logic [WIDTH-1:0] i_cfg_limit,
  input  logic             i_cfg_mode,
  input  logic             i_start,
  input  logic             i_pause,
  input  logic             i_abort,
  output logic [WIDTH-1:0] o_value,
  output logic [LAP_W-1:0] o_laps,
  output logic             o_wrap,
  output logic             o_done,
  output logic             o_busy,
  output logic [1:0]       o_state
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] DEF_LIMIT = WIDTH'(DEFAULT_LIMIT);
  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [LAP_W-1:0] LAPS_MAX  = '1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] value_q, value_d;
  logic [WIDTH-1:0] limit_q, limit_d;
  logic [LAP_W-1:0] laps_q, laps_d;
  logic             mode_q, mode_d;
  logic             wrap_q, wrap_d;
  logic             done_q, done_d;
  logic             cfg_take;
  logic             at_last;

  // Config handshake: a word transfers on any edge where i_cfg_valid and
  // o_cfg_ready are both high; ready depends only on state (IDLE/DONE).
  assign o_cfg_ready = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign o_busy      = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign cfg_take    = i_cfg_valid && o_cfg_ready;
  assign at_last     = (value_q == (limit_q - ONE));

  always_comb begin
    state_d = state_q;
    value_d = value_q;
    laps_d  = laps_q;
    limit_d = limit_q;
    mode_d  = mode_q;
    wrap_d  = 1'b0;
    done_d  = 1'b0;

    if (cfg_take) begin
      limit_d = (i_cfg_limit == '0) ? ONE : i_cfg_limit;
      mode_d  = i_cfg_mode;
    end

    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (i_start) begin
          state_d = ST_RUN;
          value_d = '0;
          laps_d  = '0;
        end
      end
      ST_RUN: begin
        if (i_abort) begin
          state_d = ST_IDLE;
          value_d = '0;
          laps_d  = '0;
        end else if (i_pause) begin
          state_d = ST_PAUSE;
        end else if (!mode_q) begin
          if (at_last) begin
            value_d = limit_q;
            state_d = ST_DONE;
            done_d  = 1'b1;
          end else begin
            value_d = value_q + ONE;
          end
        end else begin
          if (at_last) begin
            value_d = '0;
            wrap_d  = 1'b1;
            laps_d  = (laps_q == LAPS_MAX) ? laps_q : laps_q + 1'b1;
          end else begin
            value_d = value_q + ONE;
          end
        end
      end
      ST_PAUSE: begin
        if (i_abort) begin
          state_d = ST_IDLE;
          value_d = '0;
          laps_d  = '0;
        end else if (!i_pause) begin
          state_d = ST_RUN;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset_async_n) begin
    if (!i_reset_async_n) begin
      state_q <= ST_IDLE;
      value_q <= '0;
      laps_q  <= '0;
      limit_q <= DEF_LIMIT;
      mode_q  <= 1'b0;
      wrap_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      value_q <= value_d;
      laps_q  <= laps_d;
      limit_q <= limit_d;
      mode_q  <= mode_d;
      wrap_q  <= wrap_d;
      done_q  <= done_d;
    end
  end

  assign o_value = value_q;
  assign o_laps  = laps_q;
  assign o_wrap  = wrap_q;
  assign o_done  = done_q;
  assign o_state = state_q;

endmodule
